// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter in front of a shared combinational ALU.
//               The winner's operands and opcode are registered onto alu_a,
//               alu_b and alu_op. The ALU result is captured one cycle later.
//               A done pulse is returned to the owner one cycle after that.
//               Configuration macro ALU_ARB_RR_EN:
//                 defined   -> round-robin between simultaneous requests
//                 undefined -> fixed priority, requester 0 wins
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Arbitration only happens outside EXEC, and never while reset is asserted
  // so that a grant cannot be issued for a transaction that would be wiped.
  logic arb_en;
  logic grant_any;
  logic winner;

  assign arb_en    = (state_q != ST_EXEC) && !reset;
  assign grant_any = arb_en && (req0 || req1);

`ifdef ALU_ARB_RR_EN
  // Pointer names the requester that wins when both ask in the same cycle.
  logic ptr_q, ptr_d;

  // Winner selection: pointer holder wins a tie, otherwise the lone requester.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ptr_q;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  // Pointer moves to the requester that did not receive the grant.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = ~winner;
    end
  end

  // Pointer register, restarts at requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is not asking.
  assign winner = req1 & ~req0;
`endif

  assign gnt0 = grant_any && !winner;
  assign gnt1 = grant_any &&  winner;

  // Next-state and datapath load control.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (grant_any) begin
          state_d  = ST_EXEC;
          owner_d  = winner;
          alu_a_d  = winner ? a1  : a0;
          alu_b_d  = winner ? b1  : b0;
          alu_op_d = winner ? op1 : op0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Operands have been stable on the ALU for this whole cycle.
        result_d = alu_c;
        state_d  = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 3'b000;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
    end
  end

  assign done0  = (state_q == ST_DONE) && !owner_q;
  assign done1  = (state_q == ST_DONE) &&  owner_q;
  assign busy   = (state_q == ST_EXEC);
  assign result = result_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a transaction-level
//               reference model (pending-completion queue) and the team ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   op0, op1;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [W-1:0] result, alu_a, alu_b, alu_c;
  logic [2:0]   alu_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Team ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 not a.
  function automatic logic [W-1:0] team_alu(input logic [2:0] op,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    case (op)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return x << y[4:0];
      3'd6:    return x >> y[4:0];
      default: return ~x;
    endcase
  endfunction

  assign alu_c = team_alu(alu_op, alu_a, alu_b);

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .busy(busy)
  );

  // Reference model: each accepted operation completes exactly two cycles
  // after its grant; the ALU is unavailable in the cycle right after a grant.
  typedef struct {
    int           due;
    bit           who;
    logic [W-1:0] res;
  } op_t;
  op_t          pend[$];
  int           cyc;
  int           last_gnt;
`ifdef ALU_ARB_RR_EN
  bit           ptr;
`endif
  bit           e_g0, e_g1, e_d0, e_d1, e_busy;
  logic [W-1:0] e_a, e_b, e_res;
  logic [2:0]   e_op;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs, then compare all outputs against the model.
  task automatic cyc_begin(input bit rst, input bit q0, input bit q1,
                           input logic [W-1:0] ia0, input logic [W-1:0] ib0, input logic [2:0] iop0,
                           input logic [W-1:0] ia1, input logic [W-1:0] ib1, input logic [2:0] iop1);
    bit win;
    reset = rst; req0 = q0; req1 = q1;
    a0 = ia0; b0 = ib0; op0 = iop0;
    a1 = ia1; b1 = ib1; op1 = iop1;
    @(negedge clk);
    e_busy = (last_gnt == cyc - 1);
    e_d0 = 1'b0;
    e_d1 = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].who) e_d1 = 1'b1;
      else             e_d0 = 1'b1;
      e_res = pend[0].res;
    end
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!rst && !e_busy && (q0 || q1)) begin
      win = q1;
      if (q0 && q1) begin
`ifdef ALU_ARB_RR_EN
        win = ptr;
`else
        win = 1'b0;
`endif
      end
      if (win) e_g1 = 1'b1;
      else     e_g0 = 1'b1;
    end
    chk("gnt0",   gnt0,   e_g0);
    chk("gnt1",   gnt1,   e_g1);
    chk("done0",  done0,  e_d0);
    chk("done1",  done1,  e_d1);
    chk("busy",   busy,   e_busy);
    chk("result", result, e_res);
    chk("alu_a",  alu_a,  e_a);
    chk("alu_b",  alu_b,  e_b);
    chk("alu_op", alu_op, e_op);
  endtask

  // Advance the model across the rising edge and move to the next cycle.
  task automatic cyc_end();
    if (reset) begin
      pend.delete();
      last_gnt = -10;
`ifdef ALU_ARB_RR_EN
      ptr = 1'b0;
`endif
      e_a = '0; e_b = '0; e_op = 3'b000; e_res = '0;
    end else begin
      if (e_d0 || e_d1) void'(pend.pop_front());
      if (e_g0 || e_g1) begin
        last_gnt = cyc;
        e_a  = e_g1 ? a1  : a0;
        e_b  = e_g1 ? b1  : b0;
        e_op = e_g1 ? op1 : op0;
        pend.push_back('{due: cyc + 2, who: e_g1, res: team_alu(e_op, e_a, e_b)});
`ifdef ALU_ARB_RR_EN
        ptr = e_g0;
`endif
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    cyc_begin(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, '0, '0, 3'd0);
    cyc_end();
  endtask

  initial begin
    bit rst, q0, q1;
    cyc = 0; last_gnt = -10;
`ifdef ALU_ARB_RR_EN
    ptr = 1'b0;
`endif
    e_a = '0; e_b = '0; e_op = 3'b000; e_res = '0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = 3'd0; op1 = 3'd0;
    @(posedge clk); @(posedge clk); #1;

    // Reset state, grants held low while reset is high despite requests
    cyc_begin(1'b1, 1'b1, 1'b1, 32'd1, 32'd2, 3'd3, 32'd4, 32'd5, 3'd6);
    cyc_end();

    // Single add from requester 0: gnt N, done N+2
    cyc_begin(1'b0, 1'b1, 1'b0, 32'hf0000010, 32'h10, 3'd0, '0, '0, 3'd0);
    chk("add_gnt0", gnt0, 1'b1);
    cyc_end();
    cyc_begin(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, '0, '0, 3'd0);
    chk("add_busy", busy, 1'b1);
    cyc_end();
    cyc_begin(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, '0, '0, 3'd0);
    chk("add_done0", done0, 1'b1);
    chk("add_result", result, 32'hf0000020);
    cyc_end();
    idle_step();

    // Back-to-back add then subtract from requester 0
    cyc_begin(1'b0, 1'b1, 1'b0, 32'hf0000010, 32'h10, 3'd0, '0, '0, 3'd0);
    cyc_end();
    cyc_begin(1'b0, 1'b1, 1'b0, 32'hf0000010, 32'h10, 3'd0, '0, '0, 3'd0);
    chk("b2b_no_gnt_exec", gnt0, 1'b0);
    cyc_end();
    cyc_begin(1'b0, 1'b1, 1'b0, 32'h1, 32'h10, 3'd1, '0, '0, 3'd0);
    chk("b2b_done_first", done0, 1'b1);
    chk("b2b_res_first", result, 32'hf0000020);
    chk("b2b_regrant", gnt0, 1'b1);
    cyc_end();
    idle_step();
    cyc_begin(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, '0, '0, 3'd0);
    chk("b2b_done_second", done0, 1'b1);
    chk("b2b_res_second", result, 32'hfffffff1);
    cyc_end();

    // Both requesting continuously from reset
    cyc_begin(1'b1, 1'b0, 1'b0, '0, '0, 3'd0, '0, '0, 3'd0);
    cyc_end();
    for (int k = 0; k < 8; k++) begin
      cyc_begin(1'b0, 1'b1, 1'b1, W'(k), 32'd1, 3'd0, W'(100 + k), 32'd1, 3'd0);
      if (k % 2 == 0) begin
`ifdef ALU_ARB_RR_EN
        chk("both_gnt0", gnt0, (k % 4 == 0));
        chk("both_gnt1", gnt1, (k % 4 == 2));
`else
        chk("both_gnt0", gnt0, 1'b1);
        chk("both_gnt1", gnt1, 1'b0);
`endif
      end else begin
        chk("both_busy", busy, 1'b1);
      end
      cyc_end();
    end
    idle_step(); idle_step(); idle_step();

    // Requester 1 arrives during requester 0's EXEC
    cyc_begin(1'b0, 1'b1, 1'b0, 32'd7, 32'd8, 3'd0, '0, '0, 3'd0);
    chk("late_gnt0", gnt0, 1'b1);
    cyc_end();
    cyc_begin(1'b0, 1'b0, 1'b1, '0, '0, 3'd0, 32'd20, 32'd3, 3'd1);
    chk("late_no_gnt1_exec", gnt1, 1'b0);
    cyc_end();
    cyc_begin(1'b0, 1'b0, 1'b1, '0, '0, 3'd0, 32'd20, 32'd3, 3'd1);
    chk("late_done0", done0, 1'b1);
    chk("late_gnt1", gnt1, 1'b1);
    chk("late_res0", result, 32'd15);
    cyc_end();
    idle_step();
    cyc_begin(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, '0, '0, 3'd0);
    chk("late_done1", done1, 1'b1);
    chk("late_res1", result, 32'd17);
    cyc_end();

    // Reset during EXEC aborts the operation
    cyc_begin(1'b0, 1'b1, 1'b0, 32'd5, 32'd6, 3'd0, '0, '0, 3'd0);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b0, '0, '0, 3'd0, '0, '0, 3'd0);
    chk("abort_busy_exec", busy, 1'b1);
    cyc_end();
    cyc_begin(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, '0, '0, 3'd0);
    chk("abort_idle", busy, 1'b0);
    chk("abort_result", result, 32'd0);
    chk("abort_no_done", done0, 1'b0);
    cyc_end();
    cyc_begin(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, '0, '0, 3'd0);
    chk("abort_no_done_late", done0, 1'b0);
    cyc_end();

    // Randomized traffic with occasional resets outside completion cycles
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0) && !(pend.size() > 0 && pend[0].due == cyc);
      q0  = ($urandom_range(0, 2) != 0);
      q1  = ($urandom_range(0, 2) != 0);
      cyc_begin(rst, q0, q1,
                W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
      cyc_end();
    end
    idle_step(); idle_step(); idle_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
